// File: rtl/multiport_regfile_if.sv
// Bus bundle between decode/writeback (master) and the multiport register file (slave).
// Read, write, claim and scoreboard signals; ports are packed with port p at [p*W +: W].
interface multiport_regfile_if #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned REG_AMT     = 4,
  parameter int unsigned READ_PORTS  = 2,
  parameter int unsigned WRITE_PORTS = 1
);
  localparam int unsigned AW = (REG_AMT > 1) ? $clog2(REG_AMT) : 1;

  logic [READ_PORTS*AW-1:0]          rd_adrs;
  logic [READ_PORTS*DATA_WIDTH-1:0]  rd_data;
  logic [READ_PORTS-1:0]             rd_hazard;
  logic [WRITE_PORTS-1:0]            wr_en;
  logic [WRITE_PORTS*AW-1:0]         wr_adrs;
  logic [WRITE_PORTS*DATA_WIDTH-1:0] wr_data;
  logic                              claim_en;
  logic [AW-1:0]                     claim_adrs;
  logic [REG_AMT-1:0]                busy;
  logic                              wr_conflict;

  modport master (
    output rd_adrs,
    input  rd_data,
    input  rd_hazard,
    output wr_en,
    output wr_adrs,
    output wr_data,
    output claim_en,
    output claim_adrs,
    input  busy,
    input  wr_conflict
  );

  modport slave (
    input  rd_adrs,
    output rd_data,
    output rd_hazard,
    input  wr_en,
    input  wr_adrs,
    input  wr_data,
    input  claim_en,
    input  claim_adrs,
    output busy,
    output wr_conflict
  );
endinterface

// File: rtl/multiport_regfile.sv
// Parametrised register file: combinational reads with optional write bypass, synchronous
// writes (highest port wins), optional zero register and a per-register busy scoreboard.
module multiport_regfile #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned REG_AMT     = 4,
  parameter int unsigned READ_PORTS  = 2,
  parameter int unsigned WRITE_PORTS = 1,
  parameter bit          BYPASS      = 1'b1,
  parameter bit          ZERO_REG    = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  multiport_regfile_if.slave bus
);
  localparam int unsigned AW = (REG_AMT > 1) ? $clog2(REG_AMT) : 1;

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < REG_AMT;
  endfunction

  logic [DATA_WIDTH-1:0] regs_q [REG_AMT];
  logic [DATA_WIDTH-1:0] regs_d [REG_AMT];
  logic [REG_AMT-1:0]    busy_q, busy_d;
  logic                  wr_conflict_q, wr_conflict_d;

  logic [AW-1:0]         wa [WRITE_PORTS];
  logic [DATA_WIDTH-1:0] wd [WRITE_PORTS];

  logic [READ_PORTS*DATA_WIDTH-1:0] rd_data;
  logic [READ_PORTS-1:0]            rd_hazard;

  for (genvar w = 0; w < WRITE_PORTS; w++) begin : g_wr
    assign wa[w] = bus.wr_adrs[w*AW +: AW];
    assign wd[w] = bus.wr_data[w*DATA_WIDTH +: DATA_WIDTH];
  end

  // Write ports in ascending order so the highest-index port wins; the claim is applied
  // last so a new claim beats a same-cycle writeback of the old value.
  always_comb begin
    regs_d        = regs_q;
    busy_d        = busy_q;
    wr_conflict_d = 1'b0;
    for (int unsigned w = 0; w < WRITE_PORTS; w++) begin
      if (bus.wr_en[w] && in_range(wa[w])) begin
        regs_d[wa[w]] = wd[w];
        busy_d[wa[w]] = 1'b0;
      end
    end
    for (int unsigned i = 0; i < WRITE_PORTS; i++) begin
      for (int unsigned j = i + 1; j < WRITE_PORTS; j++) begin
        if (bus.wr_en[i] && bus.wr_en[j] && in_range(wa[i]) && (wa[i] == wa[j])) begin
          wr_conflict_d = 1'b1;
        end
      end
    end
    if (bus.claim_en && in_range(bus.claim_adrs)) begin
      busy_d[bus.claim_adrs] = 1'b1;
    end
    if (ZERO_REG) begin
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < REG_AMT; r++) begin
        regs_q[r] <= '0;
      end
      busy_q        <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      busy_q        <= busy_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [AW-1:0]         ra;
    logic [DATA_WIDTH-1:0] data;
    logic                  fwd;
    logic                  hz;

    assign ra = bus.rd_adrs[p*AW +: AW];

    always_comb begin
      data = '0;
      fwd  = 1'b0;
      hz   = 1'b0;
      if (in_range(ra)) begin
        data = regs_q[ra];
        if (BYPASS) begin
          for (int unsigned w = 0; w < WRITE_PORTS; w++) begin
            if (bus.wr_en[w] && (wa[w] == ra)) begin
              data = wd[w];
              fwd  = 1'b1;
            end
          end
        end
        hz = busy_q[ra] && !fwd;
      end
      if (ZERO_REG && (ra == '0)) begin
        data = '0;
      end
    end

    assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = data;
    assign rd_hazard[p]                        = hz;
  end

  assign bus.rd_data     = rd_data;
  assign bus.rd_hazard   = rd_hazard;
  assign bus.busy        = busy_q;
  assign bus.wr_conflict = wr_conflict_q;

endmodule
